mt_gen_core: RTL and testbench
==============================

Name: mt_gen_core

Overview:
- Parametrised, self-contained Mersenne Twister generator; successor to the fixed 32-bit MT core.
- Supports MT19937 (W=32) and MT19937-64 (W=64).
- Holds its own state RAM, seeding FSM and on-the-fly twist/temper pipeline.
- Delivers words over a valid/ready stream with an internal 2-entry output buffer; optional automatic seeding after reset.

Parameters:
- W, 32, word width; legal values 32 and 64 only; selects the full constant set.
- AUTO_INIT, 0, if 1, seeding with DEFAULT_SEED starts automatically on the first cycle after reset deasserts.
- DEFAULT_SEED, 5489, seed used by AUTO_INIT; truncated to W bits.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- init  input  1  single-cycle seed request; sampled every cycle
- seed  input  W  seed value, sampled in the cycle init=1
- dout  output  W  tempered random word
- dout_valid  output  1  dout holds a valid word
- dout_ready  input  1  consumer accepts dout when dout_valid=1
- busy  output  1  high while seeding is in progress

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, port reset.
- Constants for W=32: N=624, M=397, A=0x9908B0DF; U=11, D=0xFFFFFFFF; S=7, B=0x9D2C5680; T=15, C=0xEFC60000; L=18; F=1812433253; init shift 30; upper mask bit 31.
- Constants for W=64: N=312, M=156, A=0xB5026F5AA96619E9; U=29, D=0x5555555555555555; S=17, B=0x71D67FFFEDA60000; T=37, C=0xFFF7EEE000000000; L=43; F=6364136223846793005; init shift 62; upper mask bits 63:31.
- All arithmetic is modulo 2^W.
- Reset values: dout=0, dout_valid=0, busy=0. FSM goes to IDLE, output buffer is emptied, the RAM is not cleared.
- FSM states:
  - IDLE: no valid state.
  - SEED: writes one RAM word per cycle.
  - PRIME: read latency fill.
  - RUN: generation.
- IDLE: dout_valid=0. init=1 -> SEED. AUTO_INIT=1 takes this transition with DEFAULT_SEED on the cycle after reset falls.
- SEED:
  - mt[0]=seed.
  - mt[i] = F*(mt[i-1] ^ (mt[i-1]>>shift)) + i for i=1..N-1.
  - Exactly N cycles; busy=1 throughout. Then -> PRIME.
- PRIME: read mt[0], mt[1], mt[M]; -> RUN.
- RUN, per generated word, index i (0..N-1, wraps N-1 -> 0):
  - y = (mt[i] & upper) | (mt[i+1 mod N] & ~upper).
  - mt[i] := mt[(i+M) mod N] ^ (y>>1) ^ (y[0] ? A : 0).
  - mt[i+1] is held in a register as the next mt[i]. This leaves 2 RAM reads (i+1, i+M) and 1 write per cycle.
  - Read-after-write distance is never under N-M words, so no bypass is required.
- Tempering applied to the new mt[i]:
  1. y ^= (y>>U) & D
  2. y ^= (y<<S) & B
  3. y ^= (y<<T) & C
  4. y ^= y>>L
- Tempered result enters the 2-entry output buffer.
- The generator advances only when the buffer has space; it stalls (no RAM write, index held) when the buffer is full.
- Stream rules:
  - dout/dout_valid are driven from a register.
  - Once dout_valid=1, dout stays stable until the handshake (dout_valid & dout_ready).
  - No word is dropped or duplicated.
  - With dout_ready held at 1, sustained throughput is 1 word/cycle.
- Latency: first dout_valid=1 no later than N+6 cycles after the init cycle.
- init while in SEED, PRIME or RUN:
  - Aborts the current operation and restarts SEED with the new seed.
  - dout_valid=0 from the next cycle.
  - Buffer is flushed; stalled/unaccepted words are discarded.
- init and reset in the same cycle: reset wins.
- init in the same cycle as a handshake: the handshake completes, then the flush applies.
- Index wrap after N words continues the sequence seamlessly (word N+1 = first word of the second twist).

Test Plan:
- W=32, init seed=5489, dout_ready=1 -> first words 3499211612, 581869302, 3890346734; busy high exactly 624 cycles; dout_valid within 630 cycles of init.
- W=32, same seed, consume 1000 words with random dout_ready -> word #1000 equals 1067 C reference output; dout stable whenever valid&!ready; no gaps or repeats.
- W=64, seed=5489 -> first word 14514284786278117030; second 4620546740167642908.
- AUTO_INIT=1, W=32, no init pulse -> after reset, first word 3499211612 with no host action.
- W=32, init seed=1 mid-stream after 700 words, with dout_valid=1 and dout_ready=0 -> dout_valid drops next cycle; subsequent first word 1791095845.
- Reset asserted during SEED, then init seed=5489 -> identical sequence to the first scenario; busy=0 and dout_valid=0 during and right after reset.

Source files
------------

// File: rtl/mt_gen_core.sv
// mt_gen_core: parametrised Mersenne Twister generator (MT19937 for W=32,
// MT19937-64 for W=64) with internal state RAM, seeding FSM, on-the-fly
// twist/temper and a 2-entry valid/ready output buffer.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   init       one-cycle seed request (restarts seeding from any state)
//   seed       seed value, sampled with init
//   dout       tempered word (registered)
//   dout_valid dout holds a word
//   dout_ready consumer accepts dout
//   busy       seeding in progress
module mt_gen_core #(
  parameter int          W            = 32,
  parameter bit          AUTO_INIT    = 1'b0,
  parameter logic [63:0] DEFAULT_SEED = 64'd5489
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [W-1:0] seed,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy
);

  localparam bit IS64 = (W == 64);
  localparam int N    = IS64 ? 312 : 624;
  localparam int M    = IS64 ? 156 : 397;
  localparam int IW   = $clog2(N);
  localparam int U    = IS64 ? 29 : 11;
  localparam int S    = IS64 ? 17 : 7;
  localparam int T    = IS64 ? 37 : 15;
  localparam int L    = IS64 ? 43 : 18;
  localparam int SH   = IS64 ? 62 : 30;

  localparam logic [63:0] A64  = IS64 ? 64'hB502_6F5A_A966_19E9 : 64'h9908_B0DF;
  localparam logic [63:0] D64  = IS64 ? 64'h5555_5555_5555_5555 : 64'hFFFF_FFFF;
  localparam logic [63:0] B64  = IS64 ? 64'h71D6_7FFF_EDA6_0000 : 64'h9D2C_5680;
  localparam logic [63:0] C64  = IS64 ? 64'hFFF7_EEE0_0000_0000 : 64'hEFC6_0000;
  localparam logic [63:0] F64  = IS64 ? 64'd6364136223846793005 : 64'd1812433253;
  localparam logic [63:0] UP64 = IS64 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000;

  localparam logic [W-1:0] A     = A64[W-1:0];
  localparam logic [W-1:0] D     = D64[W-1:0];
  localparam logic [W-1:0] B     = B64[W-1:0];
  localparam logic [W-1:0] C     = C64[W-1:0];
  localparam logic [W-1:0] F     = F64[W-1:0];
  localparam logic [W-1:0] UPPER = UP64[W-1:0];
  localparam logic [W-1:0] DSEED = DEFAULT_SEED[W-1:0];

  typedef enum logic [1:0] {IDLE, SEED, PRIME, RUN} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   mt_ram [N];
  logic [IW-1:0]  idx, idx1, idx_m;
  logic [IW:0]    idx_sum;
  logic [W-1:0]   cur;        // mt[i] during RUN, mt[i-1] during SEED
  logic           auto_pend;
  logic [W-1:0]   skid;
  logic           skid_valid;
  logic           start, adv, pop, ram_we;
  logic [W-1:0]   start_seed, seed_val, rd_next, rd_m, y, twist, tempered, ram_wd;

  function automatic logic [W-1:0] temper(input logic [W-1:0] x);
    logic [W-1:0] t;
    t = x ^ ((x >> U) & D);
    t = t ^ ((t << S) & B);
    t = t ^ ((t << T) & C);
    t = t ^ (t >> L);
    return t;
  endfunction

  assign busy = (state == SEED);
  assign pop  = dout_valid & dout_ready;

  always_comb begin
    start      = init | ((state == IDLE) & auto_pend);
    start_seed = init ? seed : DSEED;
    idx1       = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    idx_sum    = {1'b0, idx} + (IW + 1)'(M);
    idx_m      = (idx_sum >= (IW + 1)'(N)) ? IW'(idx_sum - (IW + 1)'(N)) : idx_sum[IW-1:0];
    // mt[i+1] at i=N-1 is the already-rewritten mt[0], as the in-place
    // algorithm requires; writes land at least N-M words ahead of reads.
    rd_next    = mt_ram[idx1];
    rd_m       = mt_ram[idx_m];
    y          = (cur & UPPER) | (rd_next & ~UPPER);
    twist      = rd_m ^ (y >> 1) ^ (y[0] ? A : '0);
    tempered   = temper(twist);
    seed_val   = (idx == '0) ? cur : F * (cur ^ (cur >> SH)) + W'(idx);
    // Advance only with buffer space; counting on registered flags keeps
    // dout_ready off the generator path while still sustaining 1 word/cycle.
    adv        = (state == RUN) & ~(dout_valid & skid_valid) & ~init;
    ram_we     = ~reset & ~init & ((state == SEED) | adv);
    ram_wd     = (state == SEED) ? seed_val : twist;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEED;
      SEED:    if (idx == IW'(N - 1)) state_nxt = PRIME;
      PRIME:   state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (init) state_nxt = SEED;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // State RAM is never reset.
  always_ff @(posedge clk) begin
    if (ram_we) mt_ram[idx] <= ram_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      cur        <= '0;
      auto_pend  <= AUTO_INIT;
      dout       <= '0;
      dout_valid <= 1'b0;
      skid       <= '0;
      skid_valid <= 1'b0;
    end else begin
      if (start) begin
        auto_pend <= 1'b0;
        idx       <= '0;
        cur       <= start_seed;
      end else begin
        case (state)
          SEED: begin
            cur <= seed_val;
            idx <= idx1;
          end
          PRIME: begin
            cur <= mt_ram[0];
            idx <= '0;
          end
          RUN: if (adv) begin
            cur <= rd_next;
            idx <= idx1;
          end
          default: ;
        endcase
      end

      if (init) begin
        dout_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (pop) begin
        if (skid_valid) begin
          dout       <= skid;
          skid       <= tempered;
          skid_valid <= adv;
        end else begin
          if (adv) dout <= tempered;
          dout_valid <= adv;
        end
      end else if (adv) begin
        if (!dout_valid) begin
          dout       <= tempered;
          dout_valid <= 1'b1;
        end else begin
          skid       <= tempered;
          skid_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mt_gen_core.sv
// tb_mt_gen_core: random-ready stream bench for mt_gen_core against a
// block-twist Mersenne Twister reference model (32- and 64-bit).
module tb_mt_gen_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i32 = 1'b0, r32 = 1'b0, dv32, b32;
  logic [31:0] s32 = '0, d32;
  logic        ia = 1'b0, ra = 1'b0, dva, ba;
  logic [31:0] sa = '0, da;
  logic        i64 = 1'b0, r64 = 1'b0, dv64, b64;
  logic [63:0] s64 = '0, d64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mt_gen_core #(.W(32)) u32 (
    .clk(clk), .reset(rst), .init(i32), .seed(s32), .dout(d32),
    .dout_valid(dv32), .dout_ready(r32), .busy(b32));

  mt_gen_core #(.W(32), .AUTO_INIT(1'b1)) ua (
    .clk(clk), .reset(rst), .init(ia), .seed(sa), .dout(da),
    .dout_valid(dva), .dout_ready(ra), .busy(ba));

  mt_gen_core #(.W(64)) u64 (
    .clk(clk), .reset(rst), .init(i64), .seed(s64), .dout(d64),
    .dout_valid(dv64), .dout_ready(r64), .busy(b64));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference model: reference-C style, whole-array twist every N draws.
  bit [31:0] m32 [624];
  int        m32_i = 624;
  bit [63:0] m64 [312];
  int        m64_i = 312;

  function automatic void m32_seed(input bit [31:0] s);
    m32[0] = s;
    for (int i = 1; i < 624; i++)
      m32[i] = 32'd1812433253 * (m32[i-1] ^ (m32[i-1] >> 30)) + 32'(i);
    m32_i = 624;
  endfunction

  function automatic bit [31:0] m32_next();
    bit [31:0] y;
    if (m32_i >= 624) begin
      for (int k = 0; k < 624; k++) begin
        y = (m32[k] & 32'h8000_0000) | (m32[(k + 1) % 624] & 32'h7FFF_FFFF);
        m32[k] = m32[(k + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908_B0DF : 32'h0);
      end
      m32_i = 0;
    end
    y = m32[m32_i];
    m32_i++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C_5680);
    y = y ^ ((y << 15) & 32'hEFC6_0000);
    return y ^ (y >> 18);
  endfunction

  function automatic void m64_seed(input bit [63:0] s);
    m64[0] = s;
    for (int i = 1; i < 312; i++)
      m64[i] = 64'd6364136223846793005 * (m64[i-1] ^ (m64[i-1] >> 62)) + 64'(i);
    m64_i = 312;
  endfunction

  function automatic bit [63:0] m64_next();
    bit [63:0] y;
    if (m64_i >= 312) begin
      for (int k = 0; k < 312; k++) begin
        y = (m64[k] & 64'hFFFF_FFFF_8000_0000) | (m64[(k + 1) % 312] & 64'h7FFF_FFFF);
        m64[k] = m64[(k + 156) % 312] ^ (y >> 1) ^ (y[0] ? 64'hB502_6F5A_A966_19E9 : 64'h0);
      end
      m64_i = 0;
    end
    y = m64[m64_i];
    m64_i++;
    y = y ^ ((y >> 29) & 64'h5555_5555_5555_5555);
    y = y ^ ((y << 17) & 64'h71D6_7FFF_EDA6_0000);
    y = y ^ ((y << 37) & 64'hFFF7_EEE0_0000_0000);
    return y ^ (y >> 43);
  endfunction

  // Compare process for the W=32 instance: every accepted word against the
  // model, stability while stalled, flush after init, state after reset.
  bit        mok = 1'b0;
  bit        prev_rst = 1'b0, prev_init = 1'b0, hold = 1'b0;
  bit [31:0] hold_d = '0;
  bit [31:0] acc_q [$];

  always @(negedge clk) begin
    if (prev_rst) begin
      chk("rst_dout", 64'(d32), 64'd0);
      chk("rst_valid", 64'(dv32), 64'd0);
      chk("rst_busy", 64'(b32), 64'd0);
    end else if (prev_init) begin
      chk("init_flush", 64'(dv32), 64'd0);
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(dv32), 64'd1);
        chk("hold_stable", 64'(d32), 64'(hold_d));
      end
      if (!rst && dv32 === 1'b1 && r32) begin
        if (mok) chk("word", 64'(d32), 64'(m32_next()));
        else     chk("unexpected_word", 64'(dv32), 64'd0);
        acc_q.push_back(d32);
      end
    end
    hold      = (dv32 === 1'b1) && !r32 && !rst && !i32;
    hold_d    = d32;
    prev_rst  = rst;
    prev_init = i32 && !rst;
    if (rst) mok = 1'b0;
    else if (i32) begin
      m32_seed(s32);
      mok = 1'b1;
      acc_q.delete();
    end
  end

  task automatic pulse32(input bit [31:0] s);
    i32 = 1'b1;
    s32 = s;
    @(posedge clk); #1;
    i32 = 1'b0;
  endtask

  task automatic wait_words(input int n, input int bound, input bit rnd, input string nm);
    int c;
    for (c = 0; c < bound && acc_q.size() < n; c++) begin
      @(posedge clk); #1;
      if (rnd) r32 = ($urandom_range(0, 3) != 0);
    end
    chk(nm, 64'(acc_q.size() >= n), 64'd1);
  endtask

  bit [31:0] ref1000, w;
  bit [63:0] w64;
  int lat, bc, gaps;

  initial begin
    // Pin the model to published reference values.
    m32_seed(32'd5489);
    for (int k = 1; k <= 10000; k++) begin
      w = m32_next();
      if (k == 1)    chk("pin32_first", 64'(w), 64'd3499211612);
      if (k == 1000) ref1000 = w;
    end
    chk("pin32_10000", 64'(w), 64'd4123659995);
    m64_seed(64'd5489);
    for (int k = 0; k < 10000; k++) w64 = m64_next();
    chk("pin64_10000", w64, 64'd9981545732273789042);
    m32_seed(32'd1);
    chk("pin32_seed1", 64'(m32_next()), 64'd1791095845);

    // Reset.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", 64'(dv32), 64'd0);
    end

    // Seed 5489, ready held high: busy length, latency, first words, no gaps.
    @(posedge clk); #1;
    r32 = 1'b1;
    i32 = 1'b1;
    s32 = 32'd5489;
    @(posedge clk); #1;
    i32 = 1'b0;
    lat = -1; bc = 0; gaps = 0;
    for (int c = 2; c <= 700; c++) begin
      @(negedge clk);
      if (b32) bc++;
      if (dv32 && lat < 0) lat = c;
      else if (lat >= 0 && !dv32) gaps++;
    end
    chk("busy_cycles", 64'(bc), 64'd624);
    chk("latency_le_630", 64'(lat > 0 && lat <= 630), 64'd1);
    chk("no_gaps", 64'(gaps), 64'd0);
    chk("first_w0", 64'(acc_q[0]), 64'd3499211612);
    chk("first_w1", 64'(acc_q[1]), 64'd581869302);
    chk("first_w2", 64'(acc_q[2]), 64'd3890346734);

    // Auto-seeded instance: words waiting with no host action.
    chk("auto_valid", 64'(dva), 64'd1);
    chk("auto_w0", 64'(da), 64'd3499211612);
    @(posedge clk); #1 ra = 1'b1;
    @(posedge clk); #1 ra = 1'b0;
    @(negedge clk);
    chk("auto_w1", 64'(da), 64'd581869302);

    // Random ready through the index wrap up to 1000 words.
    wait_words(1000, 6000, 1'b1, "consume_1000");
    chk("word_1000", 64'(acc_q[999]), 64'(ref1000));

    // Stall with a full buffer, then re-seed with 1 while valid & !ready.
    @(posedge clk); #1 r32 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_valid", 64'(dv32), 64'd1);
    pulse32(32'd1);
    r32 = 1'b1;
    wait_words(1, 700, 1'b0, "seed1_timeout");
    chk("seed1_w0", 64'(acc_q[0]), 64'd1791095845);

    // Re-seed in the same cycle as a handshake.
    repeat (10) @(posedge clk);
    #1;
    pulse32(32'd12345);
    wait_words(20, 800, 1'b0, "seed12345_words");

    // Reset in the middle of seeding, then a clean re-seed.
    pulse32(32'd5489);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("busy_in_seed", 64'(b32), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", 64'(b32), 64'd0);
      chk("post_rst_valid", 64'(dv32), 64'd0);
    end
    @(posedge clk); #1;
    pulse32(32'd5489);
    wait_words(50, 2000, 1'b1, "reseed_words");
    chk("reseed_w0", 64'(acc_q[0]), 64'd3499211612);
    chk("reseed_w1", 64'(acc_q[1]), 64'd581869302);
    chk("reseed_w2", 64'(acc_q[2]), 64'd3890346734);

    // 64-bit instance.
    @(posedge clk); #1;
    i64 = 1'b1;
    s64 = 64'd5489;
    @(posedge clk); #1 i64 = 1'b0;
    m64_seed(64'd5489);
    for (int c = 0; c < 400 && dv64 !== 1'b1; c++) @(negedge clk);
    @(negedge clk);
    chk("w64_valid", 64'(dv64), 64'd1);
    chk("w64_0", d64, 64'd14514284786278117030);
    chk("w64_0_model", d64, m64_next());
    @(posedge clk); #1 r64 = 1'b1;
    @(posedge clk); #1 r64 = 1'b0;
    @(negedge clk);
    chk("w64_1", d64, 64'd4620546740167642908);
    chk("w64_1_model", d64, m64_next());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
